ws2811_rx: RTL



---
 rtl/ws2811_rx_if.sv | 29 ++
 rtl/ws2811_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ws2811_rx_if.sv
// WS2811 receiver output bundle.
// The receiver drives it; the consumer of LED samples reads it.
interface ws2811_rx_if #(
  parameter int ADDR_W = 2
);
  logic              valid;
  logic [ADDR_W-1:0] address;
  logic [7:0]        red_out;
  logic [7:0]        green_out;
  logic [7:0]        blue_out;
  logic              frame_done;
  logic              frame_error;
  logic              overflow;
  logic              busy;

  modport master (
    output valid, address,
    output red_out, green_out, blue_out,
    output frame_done, frame_error,
    output overflow, busy
  );

  modport slave (
    input valid, address,
    input red_out, green_out, blue_out,
    input frame_done, frame_error,
    input overflow, busy
  );
endinterface

// File: rtl/ws2811_rx.sv
// WS2811 single-wire receiver: classifies high-pulse widths
// into bits and emits per-LED GRB words with frame status.
module ws2811_rx #(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 100_000_000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      DI,
  ws2811_rx_if.master rx
);

  localparam int ADDR_W = $clog2(NUM_LEDS);
  localparam int IDX_W  = $clog2(NUM_LEDS + 1);
  localparam int CYCLE_COUNT  = SYSTEM_CLOCK / 800000;
  localparam int THRESH       = (48 * CYCLE_COUNT) / 100;
  localparam int MAX_HIGH     = CYCLE_COUNT;
  localparam int RESET_DETECT = 40 * CYCLE_COUNT;
  localparam int CNT_W = $clog2(RESET_DETECT + 1);

  // cnt holds (run length - 1) since the last edge, so a
  // high of exactly THRESH cycles ends with cnt = THRESH-1.
  localparam logic [CNT_W-1:0] RD_C  = CNT_W'(RESET_DETECT);
  localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(RESET_DETECT - 1);
  localparam logic [CNT_W-1:0] MH_M1 = CNT_W'(MAX_HIGH - 1);
  localparam logic [CNT_W-1:0] TH_C  = CNT_W'(THRESH);
  localparam logic [IDX_W-1:0] NL_C  = IDX_W'(NUM_LEDS);

  typedef enum logic [1:0] {
    SYNC, IDLE, HIGH, LOW
  } state_t;

  state_t            state_q;
  logic              s1_q, s_q, sd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [4:0]        bits_q;
  logic [23:0]       sr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        red_q, grn_q, blu_q;
  logic              done_q, err_q, ovf_q, busy_q;

  logic             rise, fall, edge_s, word_done;
  logic [CNT_W-1:0] cnt_inc_d;

  assign rise      = s_q & ~sd_q;
  assign fall      = ~s_q & sd_q;
  assign edge_s    = s_q ^ sd_q;
  assign word_done = (bits_q == 5'd24);
  assign cnt_inc_d = (cnt_q == RD_C) ? cnt_q
                                     : cnt_q + 1'b1;

  // Synchronizer, run counter, decode FSM and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SYNC;
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      sd_q    <= 1'b0;
      cnt_q   <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      s1_q    <= DI;
      s_q     <= s1_q;
      sd_q    <= s_q;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= edge_s ? '0 : cnt_inc_d;

      if (word_done) begin
        bits_q <= '0;
        if (idx_q < NL_C) begin
          valid_q <= 1'b1;
          addr_q  <= idx_q[ADDR_W-1:0];
          grn_q   <= sr_q[23:16];
          red_q   <= sr_q[15:8];
          blu_q   <= sr_q[7:0];
          idx_q   <= idx_q + 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end

      unique case (state_q)
        SYNC: begin
          if (s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == RD_M1) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (fall) begin
            sr_q    <= {sr_q[22:0], (cnt_q >= TH_C)};
            bits_q  <= bits_q + 5'd1;
            state_q <= LOW;
          end else if (s_q && cnt_q == MH_M1) begin
            err_q   <= 1'b1;
            bits_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= SYNC;
          end
        end
        LOW: begin
          // Latch wins over a coincident rising edge.
          if (cnt_q == RD_M1) begin
            if (bits_q == 5'd0) done_q <= 1'b1;
            else                err_q  <= 1'b1;
            bits_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (rise) begin
            state_q <= HIGH;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign rx.valid       = valid_q;
  assign rx.address     = addr_q;
  assign rx.red_out     = red_q;
  assign rx.green_out   = grn_q;
  assign rx.blue_out    = blu_q;
  assign rx.frame_done  = done_q;
  assign rx.frame_error = err_q;
  assign rx.overflow    = ovf_q;
  assign rx.busy        = busy_q;

endmodule
